// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller slice.
// Coin values are expressed in 5-unit counts throughout.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DISPENSE,
        CHG_PULSE,
        CHG_GAP
    } state_e;

    localparam int unsigned COIN5  = 1;
    localparam int unsigned COIN10 = 2;

    typedef logic item_t;

    // Credit value of the coins presented in one cycle (both together give 3).
    function automatic logic [1:0] coinUnits(input logic rs5, input logic rs10);
        logic [1:0] u;
        u = 2'd0;
        if (rs5) u = u + 2'(COIN5);
        if (rs10) u = u + 2'(COIN10);
        return u;
    endfunction

endpackage

// File: rtl/vend_credit_acc.sv
// Credit register: adds coin value unless the sum would wrap, then subtracts.
// ovf_o flags a cycle whose addition was dropped so the caller can reject the coins.
module vend_credit_acc #(
    parameter int CREDIT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CREDIT_W-1:0] add_i,
    input  logic [CREDIT_W-1:0] sub_i,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                ovf_o
);
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W:0]   sum;

    always_comb begin
        sum      = {1'b0, credit_q} + {1'b0, add_i};
        ovf_o    = sum[CREDIT_W];
        credit_d = (ovf_o ? credit_q : sum[CREDIT_W-1:0]) - sub_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign credit_o = credit_q;

endmodule

// File: rtl/vend_ctrl.sv
// Two-item vending controller: coin credit, dispense handshake, change pulses.
// Defining VEND_TIMEOUT_EN adds a dispense watchdog with a disp_fault output.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 6,
    parameter int PRICE0   = 3,
    parameter int PRICE1   = 4
`ifdef VEND_TIMEOUT_EN
    ,
    parameter int TIMEOUT  = 16
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rs5,
    input  logic                rs10,
    input  logic                sel_valid,
    input  logic                sel,
    input  logic                cancel,
    input  logic                disp_done,
    output logic                disp_valid,
    output logic                disp_item,
    output logic                rs5out,
    output logic                coin_reject,
    output logic                price_low,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
`ifdef VEND_TIMEOUT_EN
    ,
    output logic                disp_fault
`endif
);
    state_e              state_q, state_d;
    item_t               item_q, item_d;
    logic                dispValid_q, dispItem_q, rs5out_q, coinReject_q, priceLow_q, busy_q;
    logic                priceLow_d, coinReject_d;
    logic [1:0]          units;
    logic                coinIn, ovf, timeoutHit;
    logic [CREDIT_W-1:0] addVal, subVal, selPrice;

    assign units        = coinUnits(rs5, rs10);
    assign coinIn       = rs5 | rs10;
    assign selPrice     = sel ? CREDIT_W'(PRICE1) : CREDIT_W'(PRICE0);
    assign coinReject_d = coinIn & ((state_q != IDLE) | ovf);

`ifdef VEND_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                fault_q;
    logic [CREDIT_W-1:0] itemPrice;

    assign itemPrice  = item_q ? CREDIT_W'(PRICE1) : CREDIT_W'(PRICE0);
    assign timeoutHit = (state_q == DISPENSE) && !disp_done && (wd_q == WD_W'(TIMEOUT - 1));
    assign wd_d       = (state_q == DISPENSE) ? wd_q + WD_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            fault_q <= timeoutHit;
        end
    end

    assign disp_fault = fault_q;
`else
    assign timeoutHit = 1'b0;
`endif

    // Coins only count in IDLE; a watchdog expiry puts the item price back.
    always_comb begin
        addVal = '0;
        if (state_q == IDLE) addVal = CREDIT_W'(units);
`ifdef VEND_TIMEOUT_EN
        if (timeoutHit) addVal = itemPrice;
`endif
    end

    always_comb begin
        state_d    = state_q;
        item_d     = item_q;
        subVal     = '0;
        priceLow_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cancel) begin
                    if (credit != '0) state_d = CHG_PULSE;
                end else if (sel_valid) begin
                    if (credit >= selPrice) begin
                        subVal  = selPrice;
                        item_d  = sel;
                        state_d = DISPENSE;
                    end else begin
                        priceLow_d = 1'b1;
                    end
                end
            end
            DISPENSE: begin
                if (disp_done) state_d = (credit != '0) ? CHG_PULSE : IDLE;
                else if (timeoutHit) state_d = CHG_PULSE;
            end
            CHG_PULSE: begin
                subVal  = CREDIT_W'(1);
                state_d = CHG_GAP;
            end
            CHG_GAP: state_d = (credit != '0) ? CHG_PULSE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            item_q       <= 1'b0;
            dispValid_q  <= 1'b0;
            dispItem_q   <= 1'b0;
            rs5out_q     <= 1'b0;
            coinReject_q <= 1'b0;
            priceLow_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            item_q       <= item_d;
            dispValid_q  <= (state_d == DISPENSE);
            dispItem_q   <= (state_d == DISPENSE) ? item_d : 1'b0;
            rs5out_q     <= (state_d == CHG_PULSE);
            coinReject_q <= coinReject_d;
            priceLow_q   <= priceLow_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    vend_credit_acc #(
        .CREDIT_W(CREDIT_W)
    ) u_credit (
        .clk     (clk),
        .reset   (reset),
        .add_i   (addVal),
        .sub_i   (subVal),
        .credit_o(credit),
        .ovf_o   (ovf)
    );

    assign disp_valid  = dispValid_q;
    assign disp_item   = dispItem_q;
    assign rs5out      = rs5out_q;
    assign coin_reject = coinReject_q;
    assign price_low   = priceLow_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Testbench for vend_ctrl: directed scenarios plus random traffic checked against
// a timeline model of credit, dispense and change (VEND_TIMEOUT_EN adds the watchdog case).
module tb_vend_ctrl;

    localparam int P0  = 3;
    localparam int P1  = 4;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1, rs5 = 1'b0, rs10 = 1'b0, selValid = 1'b0, sel = 1'b0;
    logic       cancel = 1'b0, dispDone = 1'b0;
    logic       disp_valid, disp_item, rs5out, coin_reject, price_low, busy;
    logic [5:0] credit;
    logic       dispFault;
    logic [11:0] outsVec, expVec;

    int checks = 0;
    int failures = 0;
    int edgeNum = 0;

    // Behavioural model: credit plus dispense / change episodes timed from their start edge.
    int mCredit, mDispStart, mChgStart, mChgK;
    bit mDisp, mItem, mChg;
    bit eReject, ePriceLow, eFault;

    always #5 clk = ~clk;

    vend_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .rs5        (rs5),
        .rs10       (rs10),
        .sel_valid  (selValid),
        .sel        (sel),
        .cancel     (cancel),
        .disp_done  (dispDone),
        .disp_valid (disp_valid),
        .disp_item  (disp_item),
        .rs5out     (rs5out),
        .coin_reject(coin_reject),
        .price_low  (price_low),
        .busy       (busy),
        .credit     (credit)
`ifdef VEND_TIMEOUT_EN
        ,
        .disp_fault (dispFault)
`endif
    );

`ifndef VEND_TIMEOUT_EN
    assign dispFault = 1'b0;
`endif

    assign outsVec = {disp_valid, disp_item, rs5out, coin_reject, price_low, busy, credit};

    function automatic logic [11:0] expv(bit dv, bit di, bit r5, bit cr, bit pl, bit b, int c);
        return {dv, di, r5, cr, pl, b, 6'(c)};
    endfunction

    task automatic modelEdge(bit rst, bit r5, bit r10, bit sv, bit s, bit cn, bit dd);
        int coins, sum, price;
        eReject = 0; ePriceLow = 0; eFault = 0;
        if (rst) begin
            mCredit = 0; mDisp = 0; mItem = 0; mChg = 0;
            return;
        end
        coins = int'(r5) + 2 * int'(r10);
        if (!mDisp && !mChg) begin
            sum = mCredit + coins;
            if (sum > 63) begin
                eReject = 1;
                sum = mCredit;
            end
            if (cn) begin
                if (mCredit > 0) begin
                    mChg = 1; mChgStart = edgeNum; mChgK = sum;
                end
            end else if (sv) begin
                price = s ? P1 : P0;
                if (mCredit >= price) begin
                    sum -= price; mDisp = 1; mItem = s; mDispStart = edgeNum;
                end else begin
                    ePriceLow = 1;
                end
            end
            mCredit = sum;
        end else begin
            eReject = (coins > 0);
            if (mDisp) begin
                if (dd) begin
                    mDisp = 0;
                    if (mCredit > 0) begin
                        mChg = 1; mChgStart = edgeNum; mChgK = mCredit;
                    end
                end
`ifdef VEND_TIMEOUT_EN
                else if (edgeNum - mDispStart == TMO) begin
                    mDisp = 0; eFault = 1;
                    mCredit += mItem ? P1 : P0;
                    mChg = 1; mChgStart = edgeNum; mChgK = mCredit;
                end
`endif
            end else if (edgeNum - mChgStart == 2 * mChgK) begin
                mChg = 0;
            end
        end
        if (mChg) mCredit = mChgK - (edgeNum - mChgStart + 1) / 2;
    endtask

    function automatic logic [11:0] modelVec();
        bit r5;
        r5 = mChg && ((edgeNum - mChgStart) % 2 == 0);
        return expv(mDisp, mDisp ? mItem : 1'b0, r5, eReject, ePriceLow, mDisp || mChg, mCredit);
    endfunction

    task automatic applyStimulus(bit rst, bit r5, bit r10, bit sv, bit s, bit cn, bit dd);
        @(negedge clk);
        reset = rst; rs5 = r5; rs10 = r10; selValid = sv; sel = s; cancel = cn; dispDone = dd;
        @(posedge clk);
        edgeNum++;
        modelEdge(rst, r5, r10, sv, s, cn, dd);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1, 1, 1, 1, 1, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        expVec = expv(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (outsVec !== expVec || dispFault !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state: got %b fault %b, expected %b fault 0", outsVec, dispFault, expVec);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (outsVec !== expVec) begin
            failures++;
            $display("[TB] FAIL reset_release: got %b, expected %b", outsVec, expVec);
        end
    endtask

    task automatic test_dispense_exact();
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (outsVec !== expv(0, 0, 0, 0, 0, 0, 2)) begin
            failures++; $display("[TB] FAIL coin10_first: got %b, expected credit 2", outsVec);
        end
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (outsVec !== expv(0, 0, 0, 0, 0, 0, 4)) begin
            failures++; $display("[TB] FAIL coin10_second: got %b, expected credit 4", outsVec);
        end
        applyStimulus(0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (outsVec !== expv(1, 1, 0, 0, 0, 1, 0)) begin
                failures++; $display("[TB] FAIL sel1_dispense: cycle %0d got %b, expected %b", i, outsVec, expv(1, 1, 0, 0, 0, 1, 0));
            end
            if (i < 2) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (outsVec !== expv(0, 0, 0, 0, 0, 0, 0)) begin
            failures++; $display("[TB] FAIL done_to_idle: got %b, expected all zero", outsVec);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (rs5out !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL no_change: rs5out %b busy %b, expected 0 0", rs5out, busy);
        end
    endtask

    task automatic test_change();
        int pulses;
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checks++;
        if (credit !== 6'd3) begin
            failures++; $display("[TB] FAIL coin_both: credit %0d, expected 3", credit);
        end
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (outsVec !== expv(1, 0, 0, 0, 0, 1, 2)) begin
            failures++; $display("[TB] FAIL sel0_accept: got %b, expected %b", outsVec, expv(1, 0, 0, 0, 0, 1, 2));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        pulses = int'(rs5out);
        for (int j = 1; j <= 4; j++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            pulses += int'(rs5out);
            expVec = (j < 4) ? expv(0, 0, (j % 2 == 0), 0, 0, 1, 2 - (j + 1) / 2) : expv(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (outsVec !== expVec) begin
                failures++; $display("[TB] FAIL change_seq: step %0d got %b, expected %b", j, outsVec, expVec);
            end
        end
        checks++;
        if (pulses != 2) begin
            failures++; $display("[TB] FAIL change_count: %0d pulses, expected 2", pulses);
        end
    endtask

    task automatic test_price_low();
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 0, 0);
        checks++;
        if (outsVec !== expv(0, 0, 0, 0, 1, 0, 2)) begin
            failures++; $display("[TB] FAIL price_low_pulse: got %b, expected %b", outsVec, expv(0, 0, 0, 0, 1, 0, 2));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (outsVec !== expv(0, 0, 0, 0, 0, 0, 2)) begin
            failures++; $display("[TB] FAIL price_low_single: got %b, expected credit 2 flags 0", outsVec);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        for (int j = 0; j <= 4; j++) begin
            if (j > 0) applyStimulus(0, 0, 0, 0, 0, 0, 0);
            expVec = (j < 4) ? expv(0, 0, (j % 2 == 0), 0, 0, 1, 2 - (j + 1) / 2) : expv(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (outsVec !== expVec) begin
                failures++; $display("[TB] FAIL cancel_change: step %0d got %b, expected %b", j, outsVec, expVec);
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 31; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (credit !== 6'd62) begin
            failures++; $display("[TB] FAIL fill_62: credit %0d, expected 62", credit);
        end
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (outsVec !== expv(0, 0, 0, 1, 0, 0, 62)) begin
            failures++; $display("[TB] FAIL overflow_reject: got %b, expected reject credit 62", outsVec);
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checks++;
        if (outsVec !== expv(0, 0, 0, 1, 0, 0, 63)) begin
            failures++; $display("[TB] FAIL full_reject: got %b, expected reject credit 63", outsVec);
        end
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (outsVec !== expv(1, 0, 0, 1, 0, 1, 60)) begin
            failures++; $display("[TB] FAIL coin_in_dispense: got %b, expected %b", outsVec, expv(1, 0, 0, 1, 0, 1, 60));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (outsVec !== expv(0, 0, 0, 0, 0, 1, 59)) begin
            failures++; $display("[TB] FAIL chg_gap_entry: got %b, expected busy credit 59", outsVec);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (outsVec !== expv(0, 0, 0, 0, 0, 0, 0)) begin
            failures++; $display("[TB] FAIL reset_mid_change: got %b, expected all zero", outsVec);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (outsVec !== expv(0, 0, 0, 0, 0, 0, 0)) begin
            failures++; $display("[TB] FAIL after_reset: got %b, expected all zero", outsVec);
        end
    endtask

    task automatic test_cancel_sel();
        int pulses = 0;
        bit sawDisp = 0;
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 1, 0);
        for (int j = 0; j <= 8; j++) begin
            if (j > 0) applyStimulus(0, 0, 0, 0, 0, 0, 0);
            pulses += int'(rs5out);
            sawDisp |= disp_valid;
            expVec = (j < 8) ? expv(0, 0, (j % 2 == 0), 0, 0, 1, 4 - (j + 1) / 2) : expv(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (outsVec !== expVec) begin
                failures++; $display("[TB] FAIL cancel_wins: step %0d got %b, expected %b", j, outsVec, expVec);
            end
        end
        checks++;
        if (pulses != 4 || sawDisp) begin
            failures++; $display("[TB] FAIL cancel_pulses: %0d pulses disp %b, expected 4 pulses disp 0", pulses, sawDisp);
        end
    endtask

`ifdef VEND_TIMEOUT_EN
    task automatic test_timeout();
        int pulses = 0;
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        for (int i = 1; i < TMO; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (dispFault !== 1'b0 || outsVec !== expv(1, 0, 0, 0, 0, 1, 0)) begin
                failures++; $display("[TB] FAIL timeout_wait: cycle %0d fault %b outs %b", i, dispFault, outsVec);
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dispFault !== 1'b1 || outsVec !== expv(0, 0, 1, 0, 0, 1, 3)) begin
            failures++; $display("[TB] FAIL timeout_fire: fault %b outs %b, expected fault 1 outs %b", dispFault, outsVec, expv(0, 0, 1, 0, 0, 1, 3));
        end
        pulses = int'(rs5out);
        for (int j = 1; j <= 6; j++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            pulses += int'(rs5out);
        end
        checks++;
        if (pulses != 3 || busy !== 1'b0 || credit !== 6'd0) begin
            failures++; $display("[TB] FAIL timeout_refund: %0d pulses busy %b credit %0d, expected 3 0 0", pulses, busy, credit);
        end
    endtask
`endif

    task automatic test_random();
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom % 400) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0,
                          ($urandom % 6) == 0, 1'($urandom), ($urandom % 25) == 0, ($urandom % 4) == 0);
            expVec = modelVec();
            checks++;
            if (outsVec !== expVec || dispFault !== eFault) begin
                failures++;
                $display("[TB] FAIL random_cycle: edge %0d got %b fault %b, expected %b fault %b",
                         edgeNum, outsVec, dispFault, expVec, eFault);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_dispense_exact();
        test_change();
        test_price_low();
        test_overflow();
        test_cancel_sel();
`ifdef VEND_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
